// File: rtl/pipe_pkg.sv
// Shared types and helpers for the EX->MEM pipeline stage.
//   occ_e          : occupancy states of the two-entry skid buffer
//   ex_mem_ctrl_t  : control bits carried from EX into MEM
//   branch_taken() : BEQ/BNE resolution from the ALU zero flag
//   misaligned()   : word-access alignment check on the low address bits
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
        logic mem2reg;
    } ex_mem_ctrl_t;

    localparam int CTRL_W = 4;

    // BEQ is taken on zero=1, BNE on zero=0.
    function automatic logic branch_taken(input logic br, input logic bne, input logic zero);
        return br & (zero ^ bne);
    endfunction

    // Any load/store whose address is not a multiple of four.
    function automatic logic misaligned(input logic mem_rd, input logic mem_wr,
                                        input logic [1:0] addr_lo);
        return (mem_rd | mem_wr) & (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer with a registered ready.
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop every held entry and the current input
//   in_valid/in_ready   : upstream handshake (in_ready comes from a flop)
//   in_data             : payload accepted on in_valid & in_ready
//   out_valid/out_ready : downstream handshake
//   out_data            : head-of-queue payload; all zero while out_valid=0
module ex_mem_skid
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state_q, state_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_xfer_s, out_xfer_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Occupancy next-state and data movement; the skid entry only fills from ONE.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        in_xfer_s   = in_valid & in_ready_q;
        out_xfer_s  = out_valid_q & out_ready;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer_s) begin
                        state_d    = ONE;
                        out_data_d = in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        out_data_d = in_data;
                    end else if (in_xfer_s) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                    end else if (out_xfer_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_xfer_s) begin
                        state_d    = ONE;
                        out_data_d = skid_data_q;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        // An empty output register carries zeros so gated controls stay low.
        if (state_d == EMPTY) begin
            out_data_d = {W{1'b0}};
        end else begin
            out_data_d = out_data_d;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    // State and payload registers; ready stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= {W{1'b0}};
            skid_data_q <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: buffers ALU results and EX controls for MEM,
// resolves BEQ/BNE and flags misaligned word accesses.
//   clk, rst (async, active-low), flush
//   in_valid/in_ready, alu_result, zero, store_data, branch_target,
//   ctrl_branch, ctrl_bne, ctrl_mem_rd, ctrl_mem_wr, ctrl_reg_wr, ctrl_mem2reg, rd
//   out_valid/out_ready, out_addr, out_wdata, out_mem_rd, out_mem_wr,
//   out_reg_wr, out_mem2reg, out_rd
//   pc_src/pc_target : one-cycle taken-branch redirect
//   addr_err         : sticky misaligned-access flag, cleared only by reset
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int ANCHO_BUS = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ANCHO_BUS-1:0] alu_result,
    input  logic                 zero,
    input  logic [ANCHO_BUS-1:0] store_data,
    input  logic [ANCHO_BUS-1:0] branch_target,
    input  logic                 ctrl_branch,
    input  logic                 ctrl_bne,
    input  logic                 ctrl_mem_rd,
    input  logic                 ctrl_mem_wr,
    input  logic                 ctrl_reg_wr,
    input  logic                 ctrl_mem2reg,
    input  logic [REG_ADDR-1:0]  rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ANCHO_BUS-1:0] out_addr,
    output logic [ANCHO_BUS-1:0] out_wdata,
    output logic                 out_mem_rd,
    output logic                 out_mem_wr,
    output logic                 out_reg_wr,
    output logic                 out_mem2reg,
    output logic [REG_ADDR-1:0]  out_rd,
    output logic                 pc_src,
    output logic [ANCHO_BUS-1:0] pc_target,
    output logic                 addr_err
);

    localparam int PW = CTRL_W + REG_ADDR + 2 * ANCHO_BUS;

    ex_mem_ctrl_t         in_ctrl_s, out_ctrl_s;
    logic [PW-1:0]        in_data_s, out_data_s;
    logic                 in_xfer_s, taken_s, mis_s;
    logic                 pc_src_q, pc_src_d;
    logic [ANCHO_BUS-1:0] pc_target_q, pc_target_d;
    logic                 addr_err_q, addr_err_d;

    // Resolve branch/alignment on the offered entry and strip its side effects.
    always_comb begin
        taken_s           = branch_taken(ctrl_branch, ctrl_bne, zero);
        mis_s             = misaligned(ctrl_mem_rd, ctrl_mem_wr, alu_result[1:0]);
        in_ctrl_s.mem_rd  = ctrl_mem_rd & ~mis_s & ~ctrl_branch;
        in_ctrl_s.mem_wr  = ctrl_mem_wr & ~mis_s & ~ctrl_branch;
        in_ctrl_s.reg_wr  = ctrl_reg_wr & ~mis_s & ~ctrl_branch;
        in_ctrl_s.mem2reg = ctrl_mem2reg;
        in_data_s         = {in_ctrl_s, rd, store_data, alu_result};
    end

    ex_mem_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data_s)
    );

    assign out_addr    = out_data_s[ANCHO_BUS-1:0];
    assign out_wdata   = out_data_s[2*ANCHO_BUS-1:ANCHO_BUS];
    assign out_rd      = out_data_s[2*ANCHO_BUS+REG_ADDR-1:2*ANCHO_BUS];
    assign out_ctrl_s  = out_data_s[PW-1:PW-CTRL_W];
    assign out_mem_rd  = out_ctrl_s.mem_rd;
    assign out_mem_wr  = out_ctrl_s.mem_wr;
    assign out_reg_wr  = out_ctrl_s.reg_wr;
    assign out_mem2reg = out_ctrl_s.mem2reg;
    assign pc_src      = pc_src_q;
    assign pc_target   = pc_target_q;
    assign addr_err    = addr_err_q;

    // Redirect and error flag; a flushed input counts as never accepted.
    always_comb begin
        in_xfer_s  = in_valid & in_ready & ~flush;
        pc_src_d   = in_xfer_s & taken_s;
        addr_err_d = addr_err_q | (in_xfer_s & mis_s);
        if (pc_src_d) begin
            pc_target_d = branch_target;
        end else begin
            pc_target_d = {ANCHO_BUS{1'b0}};
        end
    end

    // Branch and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_src_q    <= 1'b0;
            pc_target_q <= {ANCHO_BUS{1'b0}};
            addr_err_q  <= 1'b0;
        end else begin
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
            addr_err_q  <= addr_err_d;
        end
    end

endmodule
